cpu_sys_nios2_qsys_0_oci_dct_packer: RTL and testbench
======================================================

// Module: cpu_sys_nios2_qsys_0_oci_dct_packer
// PURPOSE
//  Upstream stage of the OCI trace path. Packs 2-bit direct-control-transfer (DCT) branch codes
//  from the CPU trace tap into a 30-bit working buffer. Emits the buffer as one trace frame when
//  it is full, on a flush request, or when tracing is disabled.
//  dct_buffer/dct_count drive the OCI test bench and the trace frame FIFO downstream.
// PARAMETERS
//  ENTRY_W  2   bits per DCT code
//  DEPTH    15  codes per frame; BUF_W = ENTRY_W*DEPTH = 30
//  CNT_W    4   width of code count; holds 0..DEPTH
// PORTS
//  clk            in   1   single clock; all logic is rising-edge
//  reset_n        in   1   synchronous, active-low reset
//  trc_on         in   1   trace enable; a 1->0 edge acts as a flush
//  br_valid       in   1   one DCT code present this cycle
//  br_code        in   2   01 = not taken, 10 = taken; 00/11 are dropped and set bad_code
//  flush_req      in   1   indirect transfer/exception: close the current frame
//  frame_ready    in   1   downstream accepts frame this cycle
//  frame_valid    out  1   output frame register holds a frame
//  frame_data     out  30  packed codes; oldest code in the MSBs of the used span
//  frame_count    out  4   number of valid codes in frame_data (1..15)
//  frame_tstamp   out  16  cycle stamp of emission (see CONFIGURATION)
//  dct_buffer     out  30  live working buffer
//  dct_count      out  4   live working count
//  overflow       out  1   sticky: a frame was dropped
//  bad_code       out  1   sticky: an illegal br_code was seen
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): every output is 0, both registers are empty, and the timestamp counter is 0.
//    Reset applies mid-frame and discards all state.
//  Insert: trc_on & br_valid & legal code -> next buf = {buf[27:0],br_code}, next cnt = cnt+1. Latency 1 clk.
//  Emit condition, evaluated after the insert in the same cycle:
//    - cnt_next==15, or
//    - flush_req, or
//    - trc_on falling edge (registered trc_on_d & ~trc_on);
//    and cnt_next!=0 in every case.
//  Emit: the working buffer moves to the frame register. Working buffer and count clear to 0 on the next edge.
//  A branch and a flush in the same cycle: the branch is included in the emitted frame.
//  Full and flush in the same cycle: exactly one frame of 15 codes.
//  Flush with cnt_next==0: no frame and no state change.
//  Output register handshake:
//    - transfer when frame_valid & frame_ready;
//    - frame_data, frame_count and frame_tstamp hold stable while frame_valid & ~frame_ready.
//  Emit while the frame register is occupied:
//    - if frame_ready=1 that cycle, the new frame replaces it back-to-back and frame_valid stays 1;
//    - if frame_ready=0, the new frame is dropped, overflow<=1 and the working buffer is still cleared.
//  FSM for the output register: EMPTY --emit--> FULL; FULL --ready & ~emit--> EMPTY; FULL --ready & emit--> FULL.
//  trc_on=0: br_valid is ignored and no new codes are accepted. A pending frame still drains.
//  Sticky flags clear only on reset.
// CONFIGURATION
//  CPU_SYS_OCI_DCT_TSTAMP_EN defined:
//    - a 16-bit free-running cycle counter runs from reset and wraps 0xFFFF->0;
//    - its value in the emit cycle is latched into frame_tstamp with the frame.
//  Macro undefined: no counter exists and frame_tstamp is tied to 16'h0000.
// TESTING
//  1 Reset, then 15 x br_code=10 on consecutive cycles:
//    frame_valid=1 one clk after the 15th; frame_data=30'h2AAAAAAA, frame_count=15, dct_count=0.
//  2 Codes 10,01,10 then flush_req with frame_ready=1:
//    frame_data[5:0]=6'b100110, frame_count=3, overflow=0.
//  3 Hold frame_ready=0, fill a frame (15 codes), then fill a second:
//    the second is dropped, overflow=1, the first frame_data is unchanged.
//  4 br_valid(01) and flush_req in the same cycle with cnt=4: one frame, frame_count=5.
//    flush_req with cnt=0: frame_valid stays 0.
//  5 After 7 codes: a trc_on 1->0 edge emits a frame of 7; br_valid while trc_on=0 leaves dct_count=0.
//    Asserting reset_n=0 mid-frame clears dct_count, frame_valid, overflow and bad_code.
//  6 TSTAMP_EN build: flush at cycle 100 after reset gives frame_tstamp=100.
//    Non-TSTAMP build: frame_tstamp=0. br_code=11 sets bad_code=1 and dct_count is unchanged.

Source files
------------

// File: rtl/cpu_sys_nios2_qsys_0_oci_dct_packer.sv
// DCT branch-code packer: shifts 2-bit codes into a 30-bit buffer and hands full/flushed frames to a one-deep output register.
// Optional cycle timestamp on each frame is enabled with `define CPU_SYS_OCI_DCT_TSTAMP_EN.
module cpu_sys_nios2_qsys_0_oci_dct_packer #(
    parameter int ENTRY_W = 2,
    parameter int DEPTH   = 15,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trc_on,
    input  logic                     br_valid,
    input  logic [ENTRY_W-1:0]       br_code,
    input  logic                     flush_req,
    input  logic                     frame_ready,
    output logic                     frame_valid,
    output logic [ENTRY_W*DEPTH-1:0] frame_data,
    output logic [CNT_W-1:0]         frame_count,
    output logic [15:0]              frame_tstamp,
    output logic [ENTRY_W*DEPTH-1:0] dct_buffer,
    output logic [CNT_W-1:0]         dct_count,
    output logic                     overflow,
    output logic                     bad_code
);

    localparam int BUF_W = ENTRY_W * DEPTH;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    out_state_e         state_q;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUF_W-1:0]   frame_data_q;
    logic [CNT_W-1:0]   frame_count_q;
    logic               trc_on_q;
    logic               overflow_q;
    logic               bad_code_q;

    logic               code_legal;
    logic               accept;
    logic               illegal;
    logic               trc_fall;
    logic               emit;
    logic               load_frame;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        code_legal = (br_code == 2'b01) || (br_code == 2'b10);
        accept     = trc_on && br_valid && code_legal;
        illegal    = trc_on && br_valid && !code_legal;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        if (accept) begin
            buf_d = {buf_q[BUF_W-ENTRY_W-1:0], br_code};
            cnt_d = cnt_q + 1'b1;
        end
        trc_fall   = trc_on_q && !trc_on;
        // The emit decision sees the code inserted this cycle, so a same-cycle branch joins the frame.
        emit       = ((cnt_d == CNT_W'(DEPTH)) || flush_req || trc_fall) && (cnt_d != '0);
        load_frame = emit && ((state_q == ST_EMPTY) || frame_ready);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_EMPTY;
            buf_q         <= '0;
            cnt_q         <= '0;
            frame_data_q  <= '0;
            frame_count_q <= '0;
            trc_on_q      <= 1'b0;
            overflow_q    <= 1'b0;
            bad_code_q    <= 1'b0;
        end else begin
            trc_on_q <= trc_on;

            if (emit) begin
                buf_q <= '0;
                cnt_q <= '0;
            end else begin
                buf_q <= buf_d;
                cnt_q <= cnt_d;
            end

            if (illegal) begin
                bad_code_q <= 1'b1;
            end

            if (load_frame) begin
                frame_data_q  <= buf_d;
                frame_count_q <= cnt_d;
            end

            case (state_q)
                ST_EMPTY: begin
                    if (emit) begin
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (frame_ready) begin
                        if (!emit) begin
                            state_q <= ST_EMPTY;
                        end
                    end else if (emit) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

`ifdef CPU_SYS_OCI_DCT_TSTAMP_EN
    logic [15:0] tstamp_cnt_q;
    logic [15:0] frame_tstamp_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tstamp_cnt_q   <= '0;
            frame_tstamp_q <= '0;
        end else begin
            tstamp_cnt_q <= tstamp_cnt_q + 16'd1;
            if (load_frame) begin
                frame_tstamp_q <= tstamp_cnt_q;
            end
        end
    end

    assign frame_tstamp = frame_tstamp_q;
`else
    assign frame_tstamp = 16'h0000;
`endif

    assign frame_valid = (state_q == ST_FULL);
    assign frame_data  = frame_data_q;
    assign frame_count = frame_count_q;
    assign dct_buffer  = buf_q;
    assign dct_count   = cnt_q;
    assign overflow    = overflow_q;
    assign bad_code    = bad_code_q;

endmodule

// File: tb/tb_cpu_sys_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer: a vector table for single-cycle behaviour plus hand sequences for
// full frames, back-to-back replace, overflow, trace-off flush, mid-frame reset and the timestamp.
module tb_cpu_sys_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trc_on;
    logic        br_valid;
    logic [1:0]  br_code;
    logic        flush_req;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic [15:0] frame_tstamp;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        bad_code;

    int n_checks = 0;
    int n_errors = 0;

    cpu_sys_nios2_qsys_0_oci_dct_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trc_on       (trc_on),
        .br_valid     (br_valid),
        .br_code      (br_code),
        .flush_req    (flush_req),
        .frame_ready  (frame_ready),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .frame_count  (frame_count),
        .frame_tstamp (frame_tstamp),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow),
        .bad_code     (bad_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        trc_on;
        logic        br_valid;
        logic [1:0]  br_code;
        logic        flush_req;
        logic        frame_ready;
        logic        exp_fv;
        logic [29:0] exp_data;
        logic [3:0]  exp_fc;
        logic [29:0] exp_buf;
        logic [3:0]  exp_cnt;
        logic        exp_ov;
        logic        exp_bad;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Frame data/count are only meaningful while a frame is held.
    task automatic check_out(input string tag, input logic fv, input logic [29:0] data, input logic [3:0] fc,
                             input logic [29:0] bufv, input logic [3:0] cnt, input logic ov, input logic bad);
        check({tag, ".frame_valid"}, 32'(frame_valid), 32'(fv));
        if (fv) begin
            check({tag, ".frame_data"}, 32'(frame_data), 32'(data));
            check({tag, ".frame_count"}, 32'(frame_count), 32'(fc));
        end
        check({tag, ".dct_buffer"}, 32'(dct_buffer), 32'(bufv));
        check({tag, ".dct_count"}, 32'(dct_count), 32'(cnt));
        check({tag, ".overflow"}, 32'(overflow), 32'(ov));
        check({tag, ".bad_code"}, 32'(bad_code), 32'(bad));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic v, input logic [1:0] c, input logic f, input logic r);
        trc_on      = t;
        br_valid    = v;
        br_code     = c;
        flush_req   = f;
        frame_ready = r;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic t, input logic v, input logic [1:0] c, input logic f, input logic r,
                                input logic fv, input logic [29:0] d, input logic [3:0] fc,
                                input logic [29:0] b, input logic [3:0] n, input logic ov, input logic bad);
        vec_t x;
        x.trc_on = t; x.br_valid = v; x.br_code = c; x.flush_req = f; x.frame_ready = r;
        x.exp_fv = fv; x.exp_data = d; x.exp_fc = fc; x.exp_buf = b; x.exp_cnt = n;
        x.exp_ov = ov; x.exp_bad = bad;
        return x;
    endfunction

    initial begin
        // trc br  code  fl rdy | fv data        fc  buf     cnt ov bad
        vecs[0]  = mk(1, 1, 2'b10, 0, 0, 0, 30'h0,   4'd0, 30'h2,   4'd1, 0, 0);
        vecs[1]  = mk(1, 1, 2'b01, 0, 0, 0, 30'h0,   4'd0, 30'h9,   4'd2, 0, 0);
        vecs[2]  = mk(1, 1, 2'b10, 1, 1, 1, 30'h26,  4'd3, 30'h0,   4'd0, 0, 0);
        vecs[3]  = mk(1, 0, 2'b00, 0, 1, 0, 30'h0,   4'd0, 30'h0,   4'd0, 0, 0);
        vecs[4]  = mk(1, 1, 2'b01, 0, 0, 0, 30'h0,   4'd0, 30'h1,   4'd1, 0, 0);
        vecs[5]  = mk(1, 1, 2'b01, 0, 0, 0, 30'h0,   4'd0, 30'h5,   4'd2, 0, 0);
        vecs[6]  = mk(1, 1, 2'b01, 0, 0, 0, 30'h0,   4'd0, 30'h15,  4'd3, 0, 0);
        vecs[7]  = mk(1, 1, 2'b01, 0, 0, 0, 30'h0,   4'd0, 30'h55,  4'd4, 0, 0);
        vecs[8]  = mk(1, 1, 2'b01, 1, 0, 1, 30'h155, 4'd5, 30'h0,   4'd0, 0, 0);
        vecs[9]  = mk(1, 0, 2'b00, 1, 1, 0, 30'h0,   4'd0, 30'h0,   4'd0, 0, 0);
        vecs[10] = mk(1, 0, 2'b00, 1, 0, 0, 30'h0,   4'd0, 30'h0,   4'd0, 0, 0);
        vecs[11] = mk(1, 1, 2'b11, 0, 0, 0, 30'h0,   4'd0, 30'h0,   4'd0, 0, 1);
        vecs[12] = mk(1, 1, 2'b00, 0, 0, 0, 30'h0,   4'd0, 30'h0,   4'd0, 0, 1);
        vecs[13] = mk(1, 1, 2'b10, 0, 0, 0, 30'h0,   4'd0, 30'h2,   4'd1, 0, 1);

        do_reset();
        check_out("reset", 1'b0, 30'h0, 4'd0, 30'h0, 4'd0, 1'b0, 1'b0);
        check("reset.frame_count", 32'(frame_count), 32'd0);
        check("reset.frame_data", 32'(frame_data), 32'd0);
        check("reset.frame_tstamp", 32'(frame_tstamp), 32'd0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].trc_on, vecs[i].br_valid, vecs[i].br_code, vecs[i].flush_req, vecs[i].frame_ready);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_fv, vecs[i].exp_data, vecs[i].exp_fc,
                      vecs[i].exp_buf, vecs[i].exp_cnt, vecs[i].exp_ov, vecs[i].exp_bad);
        end

        // Fifteen taken codes fill exactly one frame.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
            tick();
            if (i == 13) check_out("fill14", 1'b0, 30'h0, 4'd0, 30'h0AAAAAAA, 4'd14, 1'b0, 1'b0);
        end
        check_out("full15", 1'b1, 30'h2AAAAAAA, 4'd15, 30'h0, 4'd0, 1'b0, 1'b0);

        // Second frame completes in a ready cycle: replaces the first back-to-back.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 2'b01, 1'b0, (i == 14));
            tick();
        end
        check_out("replace", 1'b1, 30'h15555555, 4'd15, 30'h0, 4'd0, 1'b0, 1'b0);

        // Third frame with ready held low is dropped and the held frame is untouched.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
            tick();
        end
        check_out("drop", 1'b1, 30'h15555555, 4'd15, 30'h0, 4'd0, 1'b1, 1'b0);

        // Set bad_code, part-fill, then reset mid-frame.
        drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
            tick();
        end
        check_out("pre_rst", 1'b1, 30'h15555555, 4'd15, 30'h2A, 4'd3, 1'b1, 1'b1);
        reset_n = 1'b0;
        tick();
        check_out("mid_rst", 1'b0, 30'h0, 4'd0, 30'h0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Trace disable flushes a partial frame of seven.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check_out("trc_off", 1'b1, 30'h2AAA, 4'd7, 30'h0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        check_out("off_ign", 1'b1, 30'h2AAA, 4'd7, 30'h0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
        tick();
        check_out("off_drain", 1'b0, 30'h0, 4'd0, 30'h0, 4'd0, 1'b0, 1'b0);

        // Timestamp: flush in the cycle where the counter reads 100.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        check_out("tstamp_frame", 1'b1, 30'h1, 4'd1, 30'h0, 4'd0, 1'b0, 1'b0);
`ifdef CPU_SYS_OCI_DCT_TSTAMP_EN
        check("frame_tstamp", 32'(frame_tstamp), 32'd100);
`else
        check("frame_tstamp", 32'(frame_tstamp), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
